// File: rtl/if_byte_fetch_pkg.sv
// if_pkg: shared fetch-stage state encoding, widths and constants
package if_pkg;
  typedef enum logic [1:0] {RUN, LAST, WAIT} state_t;
  localparam int CNT_W = 2;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/if_byte_fetch_if.sv
// if_byte_fetch_if: fetch-stage bundle toward ID (redirect, handshake) and the byte memory
interface if_byte_fetch_if #(parameter int ADDR_W = 17);
  logic branch_flag_i;
  logic [31:0] branch_target_i;
  logic id_ready_i;
  logic mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0] mem_din_i;
  logic inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  modport master (
    input branch_flag_i, branch_target_i, id_ready_i, mem_din_i,
    output mem_rd_o, mem_addr_o, inst_valid_o, pc_o, inst_o
  );
  modport slave (
    output branch_flag_i, branch_target_i, id_ready_i, mem_din_i,
    input mem_rd_o, mem_addr_o, inst_valid_o, pc_o, inst_o
  );
endinterface

// File: rtl/if_byte_fetch_icache.sv
// if_icache: direct-mapped one-word-line instruction cache, built only with IF_ICACHE_EN
module if_icache #(
  parameter int LINES = 32
) (
  input logic clk,
  input logic rst,
  input logic [29:0] lk_word,
  output logic hit,
  output logic [31:0] lk_data,
  input logic we,
  input logic [29:0] wr_word,
  input logic [31:0] wr_data
);
  localparam int IW = $clog2(LINES);
  logic [LINES-1:0] v;
  logic [29-IW:0] tag [LINES];
  logic [31:0] data [LINES];
  assign hit = v[lk_word[IW-1:0]] && tag[lk_word[IW-1:0]] == lk_word[29:IW];
  assign lk_data = data[lk_word[IW-1:0]];
  always_ff @(posedge clk)
    if (rst) v <= '0;
    else if (we) v[wr_word[IW-1:0]] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tag[wr_word[IW-1:0]] <= wr_word[29:IW];
      data[wr_word[IW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/if_byte_fetch.sv
// if_byte_fetch: byte-serial RV32I fetch stage; define IF_ICACHE_EN to add a direct-mapped I-cache
module if_byte_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int ADDR_W = 17,
  parameter int ICACHE_LINES = 32
) (
  input logic clk,
  input logic rst,
  if_byte_fetch_if.master bus
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] fpc, word, c_data;
  logic [3:0][7:0] asm_q;
  logic hit_r, c_hit, hit, live, load;
  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_chk
    $error("ICACHE_LINES must be a power of 2");
  end
`ifdef IF_ICACHE_EN
  if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk, .rst, .lk_word(fpc[31:2]), .hit(c_hit), .lk_data(c_data),
    .we(live), .wr_word(fpc[31:2]), .wr_data(word)
  );
`else
  assign c_hit = 1'b0;
  assign c_data = '0;
`endif
  assign hit = state == RUN && cnt == '0 && c_hit;
  // live: LAST cycle whose byte 3 is arriving on mem_din_i (not a cache-hit word)
  assign live = state == LAST && !hit_r;
  assign word = live ? {bus.mem_din_i, asm_q[2], asm_q[1], asm_q[0]} : asm_q;
  assign load = (state == LAST && (!bus.inst_valid_o || bus.id_ready_i)) || (state == WAIT && bus.id_ready_i);
  assign bus.mem_rd_o = !rst && state == RUN && !hit;
  assign bus.mem_addr_o = rst ? '0 : ADDR_W'(fpc + 32'(cnt));
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      fpc <= RESET_PC;
      asm_q <= '0;
      hit_r <= 1'b0;
      bus.inst_valid_o <= 1'b0;
      bus.pc_o <= '0;
      bus.inst_o <= '0;
    end else if (bus.branch_flag_i) begin
      state <= RUN;
      cnt <= '0;
      fpc <= bus.branch_target_i & ~32'd3;
      bus.inst_valid_o <= 1'b0;
    end else begin
      if (bus.inst_valid_o && bus.id_ready_i) bus.inst_valid_o <= 1'b0;
      if (live) asm_q[3] <= bus.mem_din_i;
      if (load) begin
        bus.pc_o <= fpc;
        bus.inst_o <= word;
        bus.inst_valid_o <= 1'b1;
        fpc <= fpc + 32'd4;
        state <= RUN;
      end else if (state == LAST) state <= WAIT;
      if (state == RUN) begin
        hit_r <= hit;
        if (hit) begin
          asm_q <= c_data;
          state <= LAST;
        end else begin
          if (cnt != '0) asm_q[cnt - CNT_W'(1)] <= bus.mem_din_i;
          cnt <= cnt + CNT_W'(1);
          if (cnt == '1) state <= LAST;
        end
      end
    end
endmodule
